// File: rtl/led_fade_driver.sv
// led_fade_driver: per-channel PWM LED driver with rate-limited brightness fades.
// Define LED_FADE_GAMMA_EN to map brightness to duty through a square-law curve.
module led_fade_driver #(
    parameter int N_LEDS   = 5,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 46875,
    parameter int STEP     = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [N_LEDS-1:0] target,
    output logic [N_LEDS-1:0] LED,
    output logic              busy
);
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] STEP_N  = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS+1)'(STEP);
    localparam logic [FW-1:0]       FADE_TOP = FW'(FADE_DIV - 1);
    localparam logic [FW-1:0]       FADE_ONE = FW'(1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
    logic [PWM_BITS-1:0] bright_q [N_LEDS];
    logic [PWM_BITS-1:0] bright_d [N_LEDS];
    logic [PWM_BITS-1:0] duty_q [N_LEDS];
    logic [PWM_BITS-1:0] duty_d [N_LEDS];
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                busy_q, busy_d;
    logic                pwm_wrap, fade_tick;
    logic [PWM_BITS:0]   up_sum;

`ifdef LED_FADE_GAMMA_EN
    function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
        return (b == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`else
    function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] b);
        return b;
    endfunction
`endif

    always_comb begin
        pwm_wrap   = (pwm_cnt_q == PWM_TOP);
        fade_tick  = (fade_cnt_q == FADE_TOP);
        pwm_cnt_d  = pwm_wrap ? '0 : pwm_cnt_q + PWM_ONE;
        fade_cnt_d = fade_tick ? '0 : fade_cnt_q + FADE_ONE;
        up_sum     = '0;
        busy_d     = 1'b0;
        led_d      = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            bright_d[i] = bright_q[i];
            up_sum = {1'b0, bright_q[i]} + STEP_W;
            if (fade_tick) begin
                if (target[i]) begin
                    bright_d[i] = (up_sum > {1'b0, MAX}) ? MAX : up_sum[PWM_BITS-1:0];
                end else begin
                    bright_d[i] = (bright_q[i] < STEP_N) ? '0 : bright_q[i] - STEP_N;
                end
            end
            // duty only moves at the period boundary, using the pre-tick brightness
            duty_d[i] = pwm_wrap ? duty_map(bright_q[i]) : duty_q[i];
            led_d[i]  = (duty_q[i] > pwm_cnt_q);
            busy_d    = busy_d | (bright_q[i] != (target[i] ? MAX : '0));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            led_q      <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                bright_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            for (int i = 0; i < N_LEDS; i++) begin
                bright_q[i] <= bright_d[i];
                duty_q[i]   <= duty_d[i];
            end
        end
    end

    assign LED  = led_q;
    assign busy = busy_q;

endmodule
